wave_lut_sequencer: RTL

- Playback controller for the 1024 x 16-bit signed waveform ROM (ECG LUT) feeding the FIR/IIR filter chain.
- Phase accumulator generates ROM addresses at a programmable sample rate and fractional step.
- Captures the ROM word, applies an arithmetic gain shift and presents samples on a valid/ready interface to the filter input.
- Supports one-shot and continuous playback, stop with drain, and sticky overrun detection.

---
 rtl/wavegen_pkg.sv | 22 ++
 rtl/wave_tick_div.sv | 35 +++
 rtl/wave_lut_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wavegen_pkg.sv
// Shared definitions for the waveform LUT playback slice.
// Contents: default widths, playback state encoding and the phase-width
// derivation used by wave_lut_sequencer and wave_tick_div.
package wavegen_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 6;
  localparam int DIV_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Phase accumulator width: integer address bits plus fractional bits.
  function automatic int ph_width(input int addr_w, input int frac_w);
    return addr_w + frac_w;
  endfunction

endpackage

// File: rtl/wave_tick_div.sv
// Sample-period divider.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : force the counter back to 0 (playback start)
//   i_en           : count enable (only while playing)
//   i_div          : sample period minus 1, in clocks
//   o_tick         : high for one clock every i_div+1 enabled clocks
module wave_tick_div
  import wavegen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt;

  assign o_tick = i_en && (cnt == i_div);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= o_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wave_lut_sequencer.sv
// Playback controller for the signed waveform ROM feeding the filter chain.
// A phase accumulator (ADDR_W.FRAC_W) addresses the ROM; on each divider
// tick the addressed word is shifted arithmetically and offered on a
// valid/ready interface. One-shot or looping playback, stop with drain,
// sticky overrun when a sample is dropped under backpressure.
// Ports:
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_start, i_stop           : playback control pulses
//   i_oneshot, i_div, i_step, i_shift : config, latched at start
//   o_lut_addr / i_lut_data   : ROM address out, combinational ROM data in
//   o_data, o_valid, i_ready  : sample stream to the filter
//   o_busy, o_done, o_overrun : status
module wave_lut_sequencer
  import wavegen_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_oneshot,
  input  logic [DIV_W-1:0]         i_div,
  input  logic [ADDR_W+FRAC_W-1:0] i_step,
  input  logic [3:0]               i_shift,
  output logic [ADDR_W-1:0]        o_lut_addr,
  input  logic signed [DATA_W-1:0] i_lut_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_overrun
);

  localparam int PH_W = ph_width(ADDR_W, FRAC_W);

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase;
  logic [PH_W:0]       phase_sum;
  logic [DIV_W-1:0]    div_reg;
  logic [PH_W-1:0]     step_reg;
  logic [3:0]          shift_reg;
  logic                oneshot_reg;
  logic                tick;
  logic                load;
  logic                take;
  logic                done_d;
  logic signed [DATA_W-1:0] sample;

  wave_tick_div #(.DIV_W(DIV_W)) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (load),
    .i_en    (state_q == RUN),
    .i_div   (div_reg),
    .o_tick  (tick)
  );

  assign phase_sum  = {1'b0, phase} + {1'b0, step_reg};
  assign sample     = i_lut_data >>> shift_reg;
  assign o_lut_addr = phase[PH_W-1:FRAC_W];
  assign o_busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    take    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Stop wins over a coincident tick: nothing is captured.
        if (i_stop) begin
          state_d = DRAIN;
        end else if (tick) begin
          take = 1'b1;
          if (oneshot_reg && phase_sum[PH_W]) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!o_valid || i_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      phase       <= '0;
      div_reg     <= '0;
      step_reg    <= '0;
      shift_reg   <= '0;
      oneshot_reg <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_done      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_done  <= done_d;
      if (load) begin
        div_reg     <= i_div;
        step_reg    <= i_step;
        shift_reg   <= i_shift;
        oneshot_reg <= i_oneshot;
        phase       <= '0;
        o_overrun   <= 1'b0;
      end
      // Phase advances on every tick, even when the sample is dropped,
      // so the timebase stays real-time under backpressure.
      if (take) begin
        phase <= phase_sum[PH_W-1:0];
        if (!o_valid || i_ready) begin
          o_data  <= sample;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
